chakra_epoch_scheduler: RTL and testbench

Sequencer that presents one input sample at a time to the 7-layer `tantra_snn`. For each sample it drives the input spikes and currents for a fixed presentation window, then runs a rest window so activity drains through the seven layers. It counts crown-layer output spikes per neuron and reports the winning class over a valid/ready handshake. In train mode it gates `learning_enable` and decays the STDP learning rate per sample. It sits between the sample source (host or sensor FIFO) and the SNN core.

---
 rtl/chakra_epoch_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_chakra_epoch_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chakra_epoch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : chakra_epoch_scheduler
// Brief    : Presents one sample to the SNN, drains, scans spike counts and
//            reports the winning class; decays the STDP rate in train mode.
// Revision : 1.0
// ============================================================================
module chakra_epoch_scheduler #(
    parameter int NEURONS        = 8,
    parameter int PRESENT_CYCLES = 64,
    parameter int REST_CYCLES    = 16,
    parameter int CNT_WIDTH      = 8,
    parameter int LR_INIT        = 128,
    parameter int LR_MIN         = 16,
    parameter int DECAY_SAMPLES  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    output logic                       sample_ready,
    input  logic [NEURONS-1:0]         sample_spikes,
    input  logic [8*NEURONS-1:0]       sample_current,
    input  logic                       train_mode,
    input  logic                       abort,
    output logic [NEURONS-1:0]         snn_input_spikes,
    output logic [8*NEURONS-1:0]       snn_input_current,
    output logic                       snn_learning_enable,
    output logic [7:0]                 snn_learning_rate,
    input  logic [NEURONS-1:0]         snn_output_spikes,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [$clog2(NEURONS)-1:0] result_class,
    output logic [CNT_WIDTH-1:0]       result_count,
    output logic                       result_tie,
    output logic                       busy
);

    localparam int c_IDX_W  = $clog2(NEURONS);
    localparam int c_PH_A   = (PRESENT_CYCLES > REST_CYCLES) ? PRESENT_CYCLES : REST_CYCLES;
    localparam int c_PH_MAX = (c_PH_A > NEURONS + 1) ? c_PH_A : NEURONS + 1;
    localparam int c_PH_W   = $clog2(c_PH_MAX + 1);
    localparam int c_TR_W   = $clog2(DECAY_SAMPLES + 1);

    localparam logic [c_PH_W-1:0] c_PRES_LAST = c_PH_W'(PRESENT_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_REST_LAST = c_PH_W'((REST_CYCLES > 0) ? REST_CYCLES - 1 : 0);
    localparam logic [c_PH_W-1:0] c_SCAN_DONE = c_PH_W'(NEURONS);
    localparam logic [c_TR_W-1:0] c_TR_LAST   = c_TR_W'(DECAY_SAMPLES - 1);
    localparam logic [7:0]        c_LR_INIT   = 8'(LR_INIT);
    localparam logic [7:0]        c_LR_MIN    = 8'(LR_MIN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRESENT = 3'd1,
        S_REST    = 3'd2,
        S_SCAN    = 3'd3,
        S_REPORT  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_PH_W-1:0]    r_phase;
    logic                 r_train;
    logic [CNT_WIDTH-1:0] r_cnt [NEURONS];
    logic [c_IDX_W-1:0]   r_best_idx;
    logic [CNT_WIDTH-1:0] r_best_cnt;
    logic                 r_best_tie;
    logic [c_TR_W-1:0]    r_trained;
    logic [7:0]           r_lr;

    logic                 w_accept;
    logic                 w_abort;
    logic                 w_handshake;
    logic                 w_count_en;
    logic                 w_present_last;
    logic                 w_rest_last;
    logic                 w_scan_done;
    logic [c_IDX_W-1:0]   w_scan_idx;
    logic [CNT_WIDTH-1:0] w_scan_cnt;
    logic [7:0]           w_lr_half;

    assign w_accept       = (r_state == S_IDLE) & sample_valid & sample_ready;
    assign w_abort        = abort & (r_state != S_IDLE);
    assign w_handshake    = (r_state == S_REPORT) & result_valid & result_ready;
    assign w_count_en     = (r_state == S_PRESENT) | (r_state == S_REST);
    assign w_present_last = (r_state == S_PRESENT) & (r_phase == c_PRES_LAST);
    assign w_rest_last    = (r_state == S_REST) & (r_phase == c_REST_LAST);
    assign w_scan_done    = (r_state == S_SCAN) & (r_phase == c_SCAN_DONE);
    assign w_scan_idx     = r_phase[c_IDX_W-1:0];
    assign w_scan_cnt     = r_cnt[w_scan_idx];
    assign w_lr_half      = r_lr >> 1;

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_accept) w_next = S_PRESENT;
                S_PRESENT: if (w_present_last) w_next = (REST_CYCLES == 0) ? S_SCAN : S_REST;
                S_REST:    if (w_rest_last) w_next = S_SCAN;
                S_SCAN:    if (w_scan_done) w_next = S_REPORT;
                S_REPORT:  if (w_handshake) w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept || w_abort || (w_next != r_state))
                r_phase <= '0;
            else if (w_count_en || (r_state == S_SCAN))
                r_phase <= r_phase + 1'b1;
        end
    end

    // Saturating per-neuron spike counters, live during PRESENT and REST
    generate
        for (genvar gi = 0; gi < NEURONS; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_cnt[gi] <= '0;
                else if (w_accept || w_abort)
                    r_cnt[gi] <= '0;
                else if (w_count_en && snn_output_spikes[gi] && (r_cnt[gi] != '1))
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
            end
        end
    endgenerate

    // Linear scan: lowest index wins ties, tie flag only for a nonzero best
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_idx <= '0;
            r_best_cnt <= '0;
            r_best_tie <= 1'b0;
        end else if ((r_state == S_SCAN) && !w_scan_done) begin
            if (r_phase == '0) begin
                r_best_idx <= w_scan_idx;
                r_best_cnt <= w_scan_cnt;
                r_best_tie <= 1'b0;
            end else if (w_scan_cnt > r_best_cnt) begin
                r_best_idx <= w_scan_idx;
                r_best_cnt <= w_scan_cnt;
                r_best_tie <= 1'b0;
            end else if ((w_scan_cnt == r_best_cnt) && (r_best_cnt != '0)) begin
                r_best_tie <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_ready        <= 1'b1;
            busy                <= 1'b0;
            snn_input_spikes    <= '0;
            snn_input_current   <= '0;
            snn_learning_enable <= 1'b0;
            r_train             <= 1'b0;
            result_valid        <= 1'b0;
            result_class        <= '0;
            result_count        <= '0;
            result_tie          <= 1'b0;
            r_trained           <= '0;
            r_lr                <= c_LR_INIT;
        end else if (w_abort) begin
            sample_ready        <= 1'b1;
            busy                <= 1'b0;
            snn_input_spikes    <= '0;
            snn_input_current   <= '0;
            snn_learning_enable <= 1'b0;
            result_valid        <= 1'b0;
        end else begin
            if (w_accept) begin
                sample_ready        <= 1'b0;
                busy                <= 1'b1;
                snn_input_spikes    <= sample_spikes;
                snn_input_current   <= sample_current;
                snn_learning_enable <= train_mode;
                r_train             <= train_mode;
            end
            if (w_present_last) begin
                snn_input_spikes    <= '0;
                snn_input_current   <= '0;
                snn_learning_enable <= 1'b0;
            end
            if (w_scan_done) begin
                result_valid <= 1'b1;
                result_class <= r_best_idx;
                result_count <= r_best_cnt;
                result_tie   <= r_best_tie;
            end
            if (w_handshake) begin
                result_valid <= 1'b0;
                sample_ready <= 1'b1;
                busy         <= 1'b0;
                if (r_train) begin
                    if (r_trained == c_TR_LAST) begin
                        r_trained <= '0;
                        r_lr      <= (w_lr_half < c_LR_MIN) ? c_LR_MIN : w_lr_half;
                    end else begin
                        r_trained <= r_trained + 1'b1;
                    end
                end
            end
        end
    end

    assign snn_learning_rate = r_lr;

endmodule
`default_nettype wire

// File: tb/tb_chakra_epoch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_chakra_epoch_scheduler
// Brief    : Directed self-checking bench for chakra_epoch_scheduler.
// Revision : 1.0
// ============================================================================
module tb_chakra_epoch_scheduler;

    localparam int N  = 8;
    localparam int P  = 64;
    localparam int R  = 16;
    localparam int CW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sample_valid = 1'b0;
    logic            sample_ready;
    logic [N-1:0]    sample_spikes = '0;
    logic [8*N-1:0]  sample_current = '0;
    logic            train_mode = 1'b0;
    logic            abort = 1'b0;
    logic [N-1:0]    snn_input_spikes;
    logic [8*N-1:0]  snn_input_current;
    logic            snn_learning_enable;
    logic [7:0]      snn_learning_rate;
    logic [N-1:0]    snn_output_spikes = '0;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [2:0]      result_class;
    logic [CW-1:0]   result_count;
    logic            result_tie;
    logic            busy;

    int checks = 0;
    int failures = 0;
    int pulses [N];
    int drive_cycles;
    int le_cycles;
    int latency;

    chakra_epoch_scheduler #(
        .NEURONS(N), .PRESENT_CYCLES(P), .REST_CYCLES(R), .CNT_WIDTH(CW),
        .LR_INIT(128), .LR_MIN(16), .DECAY_SAMPLES(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_spikes(sample_spikes), .sample_current(sample_current),
        .train_mode(train_mode), .abort(abort),
        .snn_input_spikes(snn_input_spikes), .snn_input_current(snn_input_current),
        .snn_learning_enable(snn_learning_enable), .snn_learning_rate(snn_learning_rate),
        .snn_output_spikes(snn_output_spikes),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .result_count(result_count),
        .result_tie(result_tie), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic clear_pulses();
        for (int i = 0; i < N; i++) pulses[i] = 0;
    endtask

    // Accept one sample, drive pulses[i] output spikes on counting cycles 1..pulses[i],
    // and measure drive length, learning-enable length and result latency.
    task automatic run_sample(input logic [N-1:0] spk, input logic [7:0] cur, input logic trn);
        sample_spikes  = spk;
        sample_current = {N{cur}};
        train_mode     = trn;
        sample_valid   = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        checks++;
        if (sample_ready !== 1'b0 || busy !== 1'b1 || snn_input_spikes !== spk
            || snn_input_current !== {N{cur}} || snn_learning_enable !== trn) begin
            failures++;
            $display("FAIL accept: ready=%b busy=%b spk=%h cur=%h le=%b required ready=0 busy=1 spk=%h cur=%h le=%b",
                     sample_ready, busy, snn_input_spikes, snn_input_current, snn_learning_enable,
                     spk, {N{cur}}, trn);
        end
        drive_cycles = 1;
        le_cycles    = snn_learning_enable ? 1 : 0;
        latency      = -1;
        for (int k = 1; k <= 200 && latency < 0; k++) begin
            for (int i = 0; i < N; i++)
                snn_output_spikes[i] = (k <= pulses[i]) && (k <= P + R);
            @(posedge clk); #1;
            if (snn_input_spikes !== '0 || snn_input_current !== '0) drive_cycles++;
            if (snn_learning_enable) le_cycles++;
            if (result_valid === 1'b1) latency = k;
        end
        snn_output_spikes = '0;
        checks++;
        if (latency < 0) begin
            failures++;
            $display("FAIL result_timeout: result_valid never rose within 200 cycles, required within 89");
        end
    endtask

    task automatic take_result(input int hold, input logic [2:0] ecls,
                               input logic [CW-1:0] ecnt, input logic etie);
        int unstable;
        unstable = 0;
        checks++;
        if (result_valid !== 1'b1 || result_class !== ecls || result_count !== ecnt || result_tie !== etie) begin
            failures++;
            $display("FAIL result: valid=%b class=%0d count=%0d tie=%b required valid=1 class=%0d count=%0d tie=%b",
                     result_valid, result_class, result_count, result_tie, ecls, ecnt, etie);
        end
        result_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            if (result_valid !== 1'b1 || result_class !== ecls || result_count !== ecnt || result_tie !== etie)
                unstable++;
        end
        if (hold > 0) begin
            checks++;
            if (unstable != 0) begin
                failures++;
                $display("FAIL result_hold: %0d unstable cycles, required 0", unstable);
            end
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || sample_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL handshake: valid=%b ready=%b busy=%b required valid=0 ready=1 busy=0",
                     result_valid, sample_ready, busy);
        end
    endtask

    task automatic check_lr(input string name, input logic [7:0] exp_lr);
        checks++;
        if (snn_learning_rate !== exp_lr) begin
            failures++;
            $display("FAIL %s: lr=%0d required %0d", name, snn_learning_rate, exp_lr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sample_ready !== 1'b1 || busy !== 1'b0 || snn_input_spikes !== '0 || snn_input_current !== '0
            || snn_learning_enable !== 1'b0 || snn_learning_rate !== 8'd128 || result_valid !== 1'b0
            || result_class !== '0 || result_count !== '0 || result_tie !== 1'b0) begin
            failures++;
            $display("FAIL reset: ready=%b busy=%b spk=%h le=%b lr=%0d valid=%b class=%0d count=%0d tie=%b required 1 0 00 0 128 0 0 0 0",
                     sample_ready, busy, snn_input_spikes, snn_learning_enable, snn_learning_rate,
                     result_valid, result_class, result_count, result_tie);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sample_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle: ready=%b busy=%b required ready=1 busy=0", sample_ready, busy);
        end
    endtask

    task automatic test_basic();
        clear_pulses();
        pulses[5] = 10;
        run_sample(8'h0F, 8'd50, 1'b0);
        checks++;
        if (drive_cycles != P) begin
            failures++;
            $display("FAIL drive_len: %0d cycles, required %0d", drive_cycles, P);
        end
        checks++;
        if (le_cycles != 0) begin
            failures++;
            $display("FAIL le_untrained: %0d cycles, required 0", le_cycles);
        end
        checks++;
        if (latency != P + R + N + 1) begin
            failures++;
            $display("FAIL latency: %0d cycles, required %0d", latency, P + R + N + 1);
        end
        take_result(0, 3'd5, 6'd10, 1'b0);
        check_lr("lr_untrained", 8'd128);
    endtask

    task automatic test_tie();
        clear_pulses();
        pulses[2] = 7;
        pulses[6] = 7;
        run_sample(8'h81, 8'd20, 1'b0);
        take_result(20, 3'd2, 6'd7, 1'b1);
    endtask

    task automatic test_saturate();
        clear_pulses();
        pulses[3] = P + R;
        pulses[7] = 5;
        run_sample(8'hF0, 8'd99, 1'b0);
        take_result(0, 3'd3, 6'd63, 1'b0);
    endtask

    task automatic test_abort();
        int bad;
        clear_pulses();
        sample_spikes  = 8'hAA;
        sample_current = {N{8'd77}};
        train_mode     = 1'b1;
        sample_valid   = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        for (int k = 1; k < 30; k++) begin
            snn_output_spikes = 8'h02;
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        snn_output_spikes = '0;
        checks++;
        if (snn_input_spikes !== '0 || snn_input_current !== '0 || snn_learning_enable !== 1'b0
            || sample_ready !== 1'b1 || busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort: spk=%h cur=%h le=%b ready=%b busy=%b valid=%b required 0 0 0 1 0 0",
                     snn_input_spikes, snn_input_current, snn_learning_enable, sample_ready, busy, result_valid);
        end
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (result_valid !== 1'b0 || sample_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_idle: %0d cycles with result_valid or not ready, required 0", bad);
        end
        pulses[4] = 3;
        run_sample(8'h11, 8'd5, 1'b0);
        take_result(0, 3'd4, 6'd3, 1'b0);
        check_lr("lr_after_abort", 8'd128);
    endtask

    task automatic run_trained(input int n, input logic [7:0] lr_before, input logic [7:0] lr_after);
        clear_pulses();
        for (int s = 1; s <= n; s++) begin
            run_sample(8'h01, 8'd10, 1'b1);
            if (s == 1) begin
                checks++;
                if (le_cycles != P) begin
                    failures++;
                    $display("FAIL le_trained: %0d cycles, required %0d", le_cycles, P);
                end
            end
            take_result(0, 3'd0, 6'd0, 1'b0);
            if (s == n - 1) check_lr("lr_before_decay", lr_before);
            if (s == n) check_lr("lr_after_decay", lr_after);
        end
    endtask

    task automatic test_lr_decay();
        run_trained(32, 8'd128, 8'd64);
        clear_pulses();
        run_sample(8'h01, 8'd10, 1'b0);
        take_result(0, 3'd0, 6'd0, 1'b0);
        check_lr("lr_untrained_hold", 8'd64);
        run_trained(32, 8'd64, 8'd32);
        run_trained(32, 8'd32, 8'd16);
        run_trained(32, 8'd16, 8'd16);
    endtask

    task automatic test_async_reset();
        sample_spikes  = 8'h3C;
        sample_current = {N{8'd9}};
        train_mode     = 1'b1;
        sample_valid   = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (snn_learning_rate !== 8'd128 || busy !== 1'b0 || sample_ready !== 1'b1
            || snn_input_spikes !== '0 || snn_learning_enable !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: lr=%0d busy=%b ready=%b spk=%h le=%b required 128 0 1 00 0",
                     snn_learning_rate, busy, sample_ready, snn_input_spikes, snn_learning_enable);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        clear_pulses();
        test_reset();
        test_basic();
        test_tie();
        test_saturate();
        test_abort();
        test_lr_decay();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
